// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory controller: access-length codes,
// FSM state and request-source encodings, and the IO-region select value.
package mem_ctrl_pkg;

  localparam logic [1:0] REQUIRE8  = 2'd0;
  localparam logic [1:0] REQUIRE16 = 2'd1;
  localparam logic [1:0] REQUIRE32 = 2'd2;

  // Value of the two address bits at IO_SEL_HI:IO_SEL_HI-1 that marks IO space
  localparam logic [1:0] IO_SEL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    SRC_LSB_LD,
    SRC_LSB_ST,
    SRC_FETCH
  } src_t;

  // Byte count for a length code; the reserved code 3 behaves as a word
  function automatic logic [2:0] len_bytes(input logic [1:0] code);
    case (code)
      REQUIRE8:  return 3'd1;
      REQUIRE16: return 3'd2;
      default:   return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Request/response and RAM-bus signals between the requesters (LSB, fetcher),
// the memory controller and the byte-wide RAM/IO bus.
interface mem_ctrl_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  rdy;
  logic                  jump_wrong;
  logic                  lsb_read_signal;
  logic                  lsb_write_signal;
  logic [1:0]            requiring_length;
  logic [ADDR_WIDTH-1:0] to_mem_addr;
  logic [31:0]           to_mem_data;
  logic                  mem_load_success;
  logic                  mem_store_success;
  logic [31:0]           from_mem_data;
  logic                  if_read_signal;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_success;
  logic [31:0]           if_data;
  logic [7:0]            mem_din;
  logic [7:0]            mem_dout;
  logic [ADDR_WIDTH-1:0] mem_a;
  logic                  mem_wr;
  logic                  io_buffer_full;

  // Requester / bus-environment side
  modport master (
    output rdy, jump_wrong, lsb_read_signal, lsb_write_signal, requiring_length,
           to_mem_addr, to_mem_data, if_read_signal, if_addr, mem_din, io_buffer_full,
    input  mem_load_success, mem_store_success, from_mem_data, if_success, if_data,
           mem_dout, mem_a, mem_wr
  );

  // Memory controller side
  modport slave (
    input  rdy, jump_wrong, lsb_read_signal, lsb_write_signal, requiring_length,
           to_mem_addr, to_mem_data, if_read_signal, if_addr, mem_din, io_buffer_full,
    output mem_load_success, mem_store_success, from_mem_data, if_success, if_data,
           mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_byte_seq.sv
// Byte counter plus the 32-bit word register that is either assembled
// little-endian from incoming bytes or sliced into outgoing bytes.
module mem_byte_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_word,
  input  logic        cap,
  input  logic [7:0]  din,
  input  logic        clr_k,
  input  logic        inc_k,
  output logic [2:0]  k,
  output logic [31:0] word_mrg,
  output logic [7:0]  byte_out
);
  import mem_ctrl_pkg::*;

  logic [31:0] word_q;
  logic [2:0]  km1;

  // Counter k: bytes received on a read, or index of next beat on a write
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       k <= 3'd0;
    else if (clr_k) k <= 3'd0;
    else if (inc_k) k <= k + 3'd1;
  end

  // Word register: store data on a write, partially assembled load on a read
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      word_q <= 32'd0;
    else if (load) word_q <= load_word;
    else if (cap)  word_q <= word_mrg;
  end

  // Byte arriving in cycle k belongs in lane k-1; merged view includes it
  always_comb begin
    km1      = k - 3'd1;
    word_mrg = word_q;
    if (k != 3'd0) word_mrg[{km1[1:0], 3'b000} +: 8] = din;
    byte_out = word_q[{k[1:0], 3'b000} +: 8];
  end

endmodule

// File: rtl/mem_ctrl.sv
// Memory controller: arbitrates LSB store/load and instruction fetch,
// serialises each request into byte accesses on the 8-bit RAM/IO bus and
// signals completion with one-cycle success pulses.
module mem_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int IO_SEL_HI  = 17
) (
  input  logic      clk,
  input  logic      rst,
  mem_ctrl_if.slave bus
);
  import mem_ctrl_pkg::*;

  state_t                state;
  src_t                  src;
  logic [ADDR_WIDTH-1:0] base;
  logic [ADDR_WIDTH-1:0] mem_a_q;
  logic [ADDR_WIDTH-1:0] beat_addr;
  logic [2:0]            len;
  logic                  wr_q;
  logic [7:0]            dout_q;
  logic                  ld_ok, st_ok, if_ok;
  logic [31:0]           ld_data_q, if_data_q;

  logic                  any_req;
  logic                  beat_stall;
  logic                  seq_load, seq_cap, seq_clr, seq_inc;
  logic [31:0]           seq_load_word;
  logic [2:0]            k;
  logic [31:0]           word_mrg;
  logic [7:0]            byte_out;

  mem_byte_seq u_seq (
    .clk       (clk),
    .rst       (rst),
    .load      (seq_load),
    .load_word (seq_load_word),
    .cap       (seq_cap),
    .din       (bus.mem_din),
    .clr_k     (seq_clr),
    .inc_k     (seq_inc),
    .k         (k),
    .word_mrg  (word_mrg),
    .byte_out  (byte_out)
  );

  assign any_req    = bus.lsb_write_signal | bus.lsb_read_signal | bus.if_read_signal;
  assign beat_addr  = base + ADDR_WIDTH'(k);
  // IO writes wait while the UART buffer is full
  assign beat_stall = (beat_addr[IO_SEL_HI -: 2] == IO_SEL) && bus.io_buffer_full;

  // Byte-sequencer controls; nothing moves while rdy is low
  always_comb begin
    seq_load      = 1'b0;
    seq_load_word = 32'd0;
    seq_cap       = 1'b0;
    seq_clr       = 1'b0;
    seq_inc       = 1'b0;
    if (bus.rdy) begin
      case (state)
        ST_IDLE: begin
          if (!bus.jump_wrong && any_req) begin
            seq_load      = 1'b1;
            seq_clr       = 1'b1;
            seq_load_word = bus.lsb_write_signal ? bus.to_mem_data : 32'd0;
          end
        end
        ST_READ: begin
          if (bus.jump_wrong) begin
            seq_clr = 1'b1;
          end else begin
            seq_cap = (k != 3'd0);
            seq_inc = (k != len);
          end
        end
        ST_WRITE: seq_inc = (k != len) && !beat_stall;
        ST_DONE:  seq_clr = 1'b1;
        default:  seq_clr = 1'b1;
      endcase
    end
  end

  // Transaction FSM with registered bus address, write strobe, data and pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      src       <= SRC_FETCH;
      base      <= '0;
      len       <= 3'd0;
      mem_a_q   <= '0;
      wr_q      <= 1'b0;
      dout_q    <= 8'd0;
      ld_ok     <= 1'b0;
      st_ok     <= 1'b0;
      if_ok     <= 1'b0;
      ld_data_q <= 32'd0;
      if_data_q <= 32'd0;
    end else if (bus.rdy) begin
      ld_ok  <= 1'b0;
      st_ok  <= 1'b0;
      if_ok  <= 1'b0;
      wr_q   <= 1'b0;
      dout_q <= 8'd0;
      case (state)
        ST_IDLE: begin
          if (!bus.jump_wrong) begin
            if (bus.lsb_write_signal) begin
              src     <= SRC_LSB_ST;
              base    <= bus.to_mem_addr;
              len     <= len_bytes(bus.requiring_length);
              mem_a_q <= bus.to_mem_addr;
              state   <= ST_WRITE;
            end else if (bus.lsb_read_signal) begin
              src     <= SRC_LSB_LD;
              base    <= bus.to_mem_addr;
              len     <= len_bytes(bus.requiring_length);
              mem_a_q <= bus.to_mem_addr;
              state   <= ST_READ;
            end else if (bus.if_read_signal) begin
              src     <= SRC_FETCH;
              base    <= bus.if_addr;
              len     <= 3'd4;
              mem_a_q <= bus.if_addr;
              state   <= ST_READ;
            end
          end
        end
        ST_READ: begin
          if (bus.jump_wrong) begin
            state <= ST_IDLE;
          end else if (k == len) begin
            if (src == SRC_FETCH) begin
              if_ok     <= 1'b1;
              if_data_q <= word_mrg;
            end else begin
              ld_ok     <= 1'b1;
              ld_data_q <= word_mrg;
            end
            state <= ST_DONE;
          end else begin
            mem_a_q <= base + ADDR_WIDTH'(k + 3'd1);
          end
        end
        ST_WRITE: begin
          if (k == len) begin
            st_ok <= 1'b1;
            state <= ST_DONE;
          end else begin
            mem_a_q <= beat_addr;
            if (!beat_stall) begin
              wr_q   <= 1'b1;
              dout_q <= byte_out;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.mem_a             = mem_a_q;
  assign bus.mem_wr            = wr_q & bus.rdy;
  assign bus.mem_dout          = dout_q;
  assign bus.mem_load_success  = ld_ok;
  assign bus.mem_store_success = st_ok;
  assign bus.if_success        = if_ok;
  assign bus.from_mem_data     = ld_data_q;
  assign bus.if_data           = if_data_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: byte RAM model on the bus, directed scenarios and a
// randomized load/store/fetch mix checked against a byte-array memory model.
module tb_mem_ctrl;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  logic [7:0]  ram       [0:4095];
  logic [7:0]  model_mem [0:4095];
  logic [39:0] wbeats[$];

  mem_ctrl_if #(.ADDR_WIDTH(32)) bus ();

  mem_ctrl #(.ADDR_WIDTH(32), .IO_SEL_HI(17)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous byte RAM: one-cycle read latency, IO region not stored
  always @(posedge clk) begin
    if (bus.rdy) begin
      bus.mem_din <= ram[bus.mem_a[11:0]];
      if (bus.mem_wr && bus.mem_a[17:16] != 2'b11) ram[bus.mem_a[11:0]] <= bus.mem_dout;
    end
  end

  // Record every committed write beat as {address, byte}
  always @(posedge clk) begin
    if (bus.mem_wr) wbeats.push_back({bus.mem_a, bus.mem_dout});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  function automatic int nbytes(input logic [1:0] rl);
    return (rl == 2'd0) ? 1 : (rl == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input int n);
    logic [31:0] w;
    logic [31:0] ai;
    w = 32'd0;
    for (int i = 0; i < n; i++) begin
      ai = a + i;
      w  = w | (32'(model_mem[ai[11:0]]) << (8 * i));
    end
    return w;
  endfunction

  task automatic set_byte(input logic [31:0] a, input logic [7:0] v);
    ram[a[11:0]]       <= v;
    model_mem[a[11:0]] = v;
  endtask

  // kind 0=load 1=store 2=fetch; returns edges from accept to pulse.
  // jw_at / frz: loop count at which jump_wrong or rdy=0 is applied for 2 edges.
  task automatic do_txn(input int kind, input logic [31:0] addr, input logic [1:0] rl,
                        input logic [31:0] wd, input int jw_at, input int frz,
                        output int lat, output logic [31:0] rd);
    int cnt;
    bit got;
    cnt = 0;
    got = 1'b0;
    rd  = 32'd0;
    case (kind)
      0: begin bus.lsb_read_signal = 1'b1; bus.to_mem_addr = addr; bus.requiring_length = rl; end
      1: begin bus.lsb_write_signal = 1'b1; bus.to_mem_addr = addr; bus.requiring_length = rl;
               bus.to_mem_data = wd; end
      default: begin bus.if_read_signal = 1'b1; bus.if_addr = addr; end
    endcase
    while (!got && cnt < 60) begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
      if (kind == 0 && bus.mem_load_success) begin got = 1'b1; rd = bus.from_mem_data; end
      if (kind == 1 && bus.mem_store_success) got = 1'b1;
      if (kind == 2 && bus.if_success) begin got = 1'b1; rd = bus.if_data; end
      if (cnt == jw_at)     bus.jump_wrong = 1'b1;
      if (cnt == jw_at + 2) bus.jump_wrong = 1'b0;
      if (cnt == frz)       bus.rdy = 1'b0;
      if (cnt == frz + 2)   bus.rdy = 1'b1;
    end
    bus.lsb_read_signal  = 1'b0;
    bus.lsb_write_signal = 1'b0;
    bus.if_read_signal   = 1'b0;
    bus.jump_wrong       = 1'b0;
    bus.rdy              = 1'b1;
    lat = cnt - 1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    vectors += 6;
    if (bus.mem_wr !== 1'b0) begin miscompares++; $display("FAIL reset_mem_wr got %b exp 0", bus.mem_wr); end
    if (bus.mem_load_success !== 1'b0 || bus.mem_store_success !== 1'b0 || bus.if_success !== 1'b0) begin
      miscompares++; $display("FAIL reset_pulses got %b%b%b exp 000", bus.mem_load_success, bus.mem_store_success, bus.if_success);
    end
    if (bus.from_mem_data !== 32'd0) begin miscompares++; $display("FAIL reset_from_mem_data got %h exp 0", bus.from_mem_data); end
    if (bus.if_data !== 32'd0) begin miscompares++; $display("FAIL reset_if_data got %h exp 0", bus.if_data); end
    if (bus.mem_dout !== 8'd0) begin miscompares++; $display("FAIL reset_mem_dout got %h exp 0", bus.mem_dout); end
    if (bus.mem_a !== 32'd0) begin miscompares++; $display("FAIL reset_mem_a got %h exp 0", bus.mem_a); end
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_lw();
    int lat; logic [31:0] rd;
    set_byte(32'h100, 8'h78); set_byte(32'h101, 8'h56);
    set_byte(32'h102, 8'h34); set_byte(32'h103, 8'h12);
    @(negedge clk);
    do_txn(0, 32'h100, 2'd2, 32'd0, -10, -10, lat, rd);
    vectors += 2;
    if (lat != 5) begin miscompares++; $display("FAIL lw_latency got %0d exp 5", lat); end
    if (rd !== 32'h12345678) begin miscompares++; $display("FAIL lw_data got %h exp 12345678", rd); end
  endtask

  task automatic test_lb();
    int lat; logic [31:0] rd;
    set_byte(32'h101, 8'hF0);
    @(negedge clk);
    do_txn(0, 32'h101, 2'd0, 32'd0, -10, -10, lat, rd);
    vectors += 3;
    if (lat != 2) begin miscompares++; $display("FAIL lb_latency got %0d exp 2", lat); end
    if (rd !== 32'h000000F0) begin miscompares++; $display("FAIL lb_data got %h exp 000000f0", rd); end
    if (bus.from_mem_data !== 32'h000000F0) begin miscompares++; $display("FAIL lb_data_hold got %h exp 000000f0", bus.from_mem_data); end
  endtask

  task automatic test_sh();
    int lat; logic [31:0] rd;
    wbeats.delete();
    do_txn(1, 32'h200, 2'd1, 32'h1234BEEF, -10, -10, lat, rd);
    model_mem[12'h200] = 8'hEF; model_mem[12'h201] = 8'hBE;
    vectors += 4;
    if (lat != 3) begin miscompares++; $display("FAIL sh_latency got %0d exp 3", lat); end
    if (wbeats.size() != 2) begin miscompares++; $display("FAIL sh_beats got %0d exp 2", wbeats.size()); end
    else begin
      if (wbeats[0] !== {32'h200, 8'hEF}) begin miscompares++; $display("FAIL sh_beat0 got %h exp 00000200ef", wbeats[0]); end
      if (wbeats[1] !== {32'h201, 8'hBE}) begin miscompares++; $display("FAIL sh_beat1 got %h exp 00000201be", wbeats[1]); end
    end
  endtask

  task automatic test_arbitration();
    bit got_ld, got_if, if_early;
    int lat;
    logic [31:0] ld_rd, if_rd;
    got_ld = 0; got_if = 0; if_early = 0; lat = 0; ld_rd = 0; if_rd = 0;
    bus.if_read_signal  = 1'b1; bus.if_addr = 32'h0;
    bus.lsb_read_signal = 1'b1; bus.to_mem_addr = 32'h10; bus.requiring_length = 2'd2;
    for (int i = 0; i < 40 && !got_ld; i++) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (bus.if_success) if_early = 1'b1;
      if (bus.mem_load_success) begin got_ld = 1'b1; ld_rd = bus.from_mem_data; end
    end
    bus.lsb_read_signal = 1'b0;
    for (int i = 0; i < 40 && !got_if; i++) begin
      @(negedge clk);
      if (bus.if_success) begin got_if = 1'b1; if_rd = bus.if_data; end
    end
    bus.if_read_signal = 1'b0;
    @(negedge clk);
    vectors += 4;
    if (if_early) begin miscompares++; $display("FAIL arb_order got fetch_first exp load_first"); end
    if (lat - 1 != 5) begin miscompares++; $display("FAIL arb_ld_latency got %0d exp 5", lat - 1); end
    if (ld_rd !== model_load(32'h10, 4)) begin miscompares++; $display("FAIL arb_ld_data got %h exp %h", ld_rd, model_load(32'h10, 4)); end
    if (!got_if || if_rd !== model_load(32'h0, 4)) begin
      miscompares++; $display("FAIL arb_if_data got %h (seen %0d) exp %h", if_rd, got_if, model_load(32'h0, 4));
    end
  endtask

  task automatic test_io_stall();
    bit wr_seen, got;
    wr_seen = 0; got = 0;
    wbeats.delete();
    bus.io_buffer_full   = 1'b1;
    bus.lsb_write_signal = 1'b1; bus.to_mem_addr = 32'h30000;
    bus.requiring_length = 2'd0; bus.to_mem_data = 32'h00000041;
    repeat (3) begin
      @(posedge clk); @(negedge clk);
      if (bus.mem_wr) wr_seen = 1'b1;
    end
    bus.io_buffer_full = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (bus.mem_store_success) got = 1'b1;
    end
    bus.lsb_write_signal = 1'b0;
    @(negedge clk);
    vectors += 3;
    if (wr_seen) begin miscompares++; $display("FAIL io_stall got mem_wr=1 exp 0 while full"); end
    if (!got) begin miscompares++; $display("FAIL io_success got 0 exp 1"); end
    if (wbeats.size() != 1 || wbeats[0] !== {32'h30000, 8'h41}) begin
      miscompares++; $display("FAIL io_beat got %0d beats exp one beat 0003000041", wbeats.size());
    end
  endtask

  task automatic test_jump_read();
    bit seen;
    int lat; logic [31:0] rd;
    seen = 0;
    bus.if_read_signal = 1'b1; bus.if_addr = 32'h300;
    repeat (3) begin
      @(posedge clk); @(negedge clk);
      if (bus.if_success) seen = 1'b1;
    end
    bus.jump_wrong = 1'b1; bus.if_read_signal = 1'b0;
    @(posedge clk); @(negedge clk);
    bus.jump_wrong = 1'b0;
    repeat (8) begin
      @(posedge clk); @(negedge clk);
      if (bus.if_success) seen = 1'b1;
    end
    vectors += 1;
    if (seen) begin miscompares++; $display("FAIL jump_read_pulse got if_success exp none"); end
    do_txn(0, 32'h300, 2'd2, 32'd0, -10, -10, lat, rd);
    vectors += 2;
    if (lat != 5) begin miscompares++; $display("FAIL jump_read_idle_latency got %0d exp 5", lat); end
    if (rd !== model_load(32'h300, 4)) begin miscompares++; $display("FAIL jump_read_after got %h exp %h", rd, model_load(32'h300, 4)); end
  endtask

  task automatic test_jump_write();
    int lat; logic [31:0] rd, wd;
    wd = $urandom;
    wbeats.delete();
    do_txn(1, 32'h900, 2'd2, wd, 2, -10, lat, rd);
    vectors += 2;
    if (lat != 5) begin miscompares++; $display("FAIL jump_write_latency got %0d exp 5", lat); end
    if (wbeats.size() != 4) begin miscompares++; $display("FAIL jump_write_beats got %0d exp 4", wbeats.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if (wbeats[i] !== {32'h900 + 32'(i), wd[8*i +: 8]}) begin
          miscompares++; $display("FAIL jump_write_beat%0d got %h exp %h", i, wbeats[i], {32'h900 + 32'(i), wd[8*i +: 8]});
        end
        model_mem[12'h900 + 12'(i)] = wd[8*i +: 8];
      end
    end
  endtask

  task automatic test_rdy_freeze();
    int lat; logic [31:0] rd;
    do_txn(0, 32'h40, 2'd2, 32'd0, -10, 3, lat, rd);
    vectors += 2;
    if (lat != 7) begin miscompares++; $display("FAIL freeze_latency got %0d exp 7", lat); end
    if (rd !== model_load(32'h40, 4)) begin miscompares++; $display("FAIL freeze_data got %h exp %h", rd, model_load(32'h40, 4)); end
  endtask

  task automatic test_random();
    int kind, n, lat;
    logic [31:0] addr, wd, rd, exp;
    logic [1:0]  rl;
    for (int t = 0; t < 24; t++) begin
      kind = $urandom_range(0, 2);
      addr = $urandom_range(0, 32'h9F0);
      rl   = 2'($urandom_range(0, 3));
      wd   = $urandom;
      n    = (kind == 2) ? 4 : nbytes(rl);
      wbeats.delete();
      do_txn(kind, addr, rl, wd, -10, -10, lat, rd);
      vectors++;
      if (lat != n + 1) begin miscompares++; $display("FAIL rnd%0d_latency kind %0d got %0d exp %0d", t, kind, lat, n + 1); end
      if (kind == 1) begin
        vectors++;
        if (wbeats.size() != n) begin miscompares++; $display("FAIL rnd%0d_beats got %0d exp %0d", t, wbeats.size(), n); end
        else begin
          for (int i = 0; i < n; i++) begin
            vectors++;
            if (wbeats[i] !== {addr + 32'(i), wd[8*i +: 8]}) begin
              miscompares++; $display("FAIL rnd%0d_beat%0d got %h exp %h", t, i, wbeats[i], {addr + 32'(i), wd[8*i +: 8]});
            end
          end
        end
        for (int i = 0; i < n; i++) model_mem[12'(addr + 32'(i))] = wd[8*i +: 8];
      end else begin
        exp = model_load(addr, n);
        vectors++;
        if (rd !== exp) begin miscompares++; $display("FAIL rnd%0d_data kind %0d got %h exp %h", t, kind, rd, exp); end
      end
    end
  endtask

  task automatic test_reset_midwrite();
    bit wr_before;
    wbeats.delete();
    bus.lsb_write_signal = 1'b1; bus.to_mem_addr = 32'hA00;
    bus.requiring_length = 2'd2; bus.to_mem_data = $urandom;
    for (int i = 0; i < 20 && wbeats.size() < 2; i++) @(negedge clk);
    wr_before = bus.mem_wr;
    rst = 1'b0;
    #1;
    vectors += 5;
    if (wr_before !== 1'b1) begin miscompares++; $display("FAIL rstw_active got mem_wr=%b exp 1", wr_before); end
    if (bus.mem_wr !== 1'b0) begin miscompares++; $display("FAIL rstw_mem_wr got %b exp 0", bus.mem_wr); end
    if (bus.mem_store_success !== 1'b0 || bus.mem_load_success !== 1'b0 || bus.if_success !== 1'b0) begin
      miscompares++; $display("FAIL rstw_pulses got %b%b%b exp 000", bus.mem_load_success, bus.mem_store_success, bus.if_success);
    end
    if (bus.mem_dout !== 8'd0) begin miscompares++; $display("FAIL rstw_mem_dout got %h exp 0", bus.mem_dout); end
    if (bus.from_mem_data !== 32'd0) begin miscompares++; $display("FAIL rstw_from_mem_data got %h exp 0", bus.from_mem_data); end
    bus.lsb_write_signal = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b0;
    bus.rdy              = 1'b1;
    bus.jump_wrong       = 1'b0;
    bus.lsb_read_signal  = 1'b0;
    bus.lsb_write_signal = 1'b0;
    bus.requiring_length = 2'd0;
    bus.to_mem_addr      = 32'd0;
    bus.to_mem_data      = 32'd0;
    bus.if_read_signal   = 1'b0;
    bus.if_addr          = 32'd0;
    bus.io_buffer_full   = 1'b0;
    for (int i = 0; i < 4096; i++) set_byte(32'(i), 8'($urandom));

    test_reset();
    test_lw();
    test_lb();
    test_sh();
    test_arbitration();
    test_io_stall();
    test_jump_read();
    test_jump_write();
    test_rdy_freeze();
    test_random();
    test_reset_midwrite();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
